culsans_soc_top: RTL and testbench

- Uncore shell of the Culsans system: a single-port core-facing memory bus feeding a word-addressed DRAM SRAM, a CLINT (msip, mtimecmp, mtime) and a simulation exit register.
- mtime advances on real-time-clock (rtc_i) edges. A write to the exit register raises exit_o, which simulation environments poll to end a run.
- Sits between the hart(s) and memory. The boot address is exported for the core's reset PC.

---
 rtl/culsans_pkg.sv | 49 ++++
 rtl/culsans_sram_1p.sv | 31 +++
 rtl/culsans_soc_top.sv | 124 ++++++++++++
 tb/tb_culsans_soc_top.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/culsans_pkg.sv
// Culsans uncore address map, bus widths and shared helpers.
// Holds the memory map constants, the decode target type, the address
// decoder and the byte-enable merge used by every writable register.
package culsans_pkg;

  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;

  localparam logic [AddrWidth-1:0] DRAMBase       = 64'h0000_0000_8000_0000;
  localparam logic [AddrWidth-1:0] DRAMSize       = 64'h0000_0000_4000_0000;
  localparam logic [AddrWidth-1:0] ClintBase      = 64'h0000_0000_0200_0000;
  localparam logic [AddrWidth-1:0] MsipOffset     = 64'h0000_0000_0000_0000;
  localparam logic [AddrWidth-1:0] MtimecmpOffset = 64'h0000_0000_0000_4000;
  localparam logic [AddrWidth-1:0] MtimeOffset    = 64'h0000_0000_0000_BFF8;
  localparam logic [AddrWidth-1:0] ExitAddr       = 64'h0000_0000_0000_3000;

  typedef enum logic [2:0] {
    TGT_ERR,
    TGT_DRAM,
    TGT_MSIP,
    TGT_MTIMECMP,
    TGT_MTIME,
    TGT_EXIT
  } target_e;

  // Expects a word-aligned address (bits [2:0] already cleared).
  function automatic target_e decode(input logic [AddrWidth-1:0] addr);
    target_e tgt;
    tgt = TGT_ERR;
    if (addr >= DRAMBase && addr < DRAMBase + DRAMSize) tgt = TGT_DRAM;
    else if (addr == ClintBase + MsipOffset)            tgt = TGT_MSIP;
    else if (addr == ClintBase + MtimecmpOffset)        tgt = TGT_MTIMECMP;
    else if (addr == ClintBase + MtimeOffset)           tgt = TGT_MTIME;
    else if (addr == ExitAddr)                          tgt = TGT_EXIT;
    return tgt;
  endfunction

  function automatic logic [DataWidth-1:0] merge_be(input logic [DataWidth-1:0] cur,
                                                    input logic [DataWidth-1:0] wdata,
                                                    input logic [DataWidth/8-1:0] be);
    logic [DataWidth-1:0] res;
    res = cur;
    for (int unsigned i = 0; i < DataWidth / 8; i++) begin
      if (be[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/culsans_sram_1p.sv
// Single-port 64-bit byte-enable SRAM with a 1-cycle registered read.
// Ports: clk, req (access strobe), we (1 = write), addr (word index),
//        be (byte enables), wdata, rdata (valid the cycle after a read).
// Storage is deliberately not reset so preloaded contents survive reset.
module culsans_sram_1p #(
  parameter int unsigned NUM_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         req,
  input  logic                         we,
  input  logic [$clog2(NUM_WORDS)-1:0] addr,
  input  logic [7:0]                   be,
  input  logic [63:0]                  wdata,
  output logic [63:0]                  rdata
);

  logic [63:0] mem [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (req) begin
      if (we) begin
        for (int unsigned i = 0; i < 8; i++) begin
          if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/culsans_soc_top.sv
// Culsans uncore shell: core-facing single-port bus decoded onto DRAM,
// a CLINT (msip, mtimecmp, mtime) and a simulation exit register.
// Ports: clk_i/rst_i (sync, active-high), rtc_i (async RTC tick source),
//        req_i/we_i/addr_i/be_i/wdata_i request, gnt_o/rvalid_o/rdata_o/err_o
//        response (rvalid one cycle after each grant), timer_irq_o, ipi_o,
//        debug_req_i/debug_req_o, boot_addr_o, exit_o.
module culsans_soc_top
  import culsans_pkg::*;
#(
  parameter logic        InclSimDTM  = 1'b0,
  parameter int unsigned NUM_WORDS   = 1024,
  parameter logic [63:0] BootAddress = culsans_pkg::DRAMBase + 64'h10_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rtc_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [63:0] addr_i,
  input  logic [7:0]  be_i,
  input  logic [63:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [63:0] rdata_o,
  output logic        err_o,
  output logic        timer_irq_o,
  output logic        ipi_o,
  input  logic        debug_req_i,
  output logic        debug_req_o,
  output logic [63:0] boot_addr_o,
  output logic [31:0] exit_o
);

  localparam int unsigned IdxW = $clog2(NUM_WORDS);

  logic [63:0] aligned;
  target_e     tgt;
  logic        acc;
  logic        wr;
  logic [63:0] reg_rdata;
  logic [63:0] sram_rdata;
  logic [63:0] rdata_q;
  logic        err_q;
  logic        resp_dram;
  logic        msip;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [2:0]  rtc_sync;
  logic        rtc_edge;

  assign gnt_o       = req_i;
  assign boot_addr_o = BootAddress;
  assign debug_req_o = InclSimDTM ? debug_req_i : 1'b0;
  assign ipi_o       = msip;

  assign aligned = addr_i & ~64'h7;
  assign tgt     = decode(aligned);
  // Requests seen while in reset are dropped, including any DRAM write.
  assign acc     = req_i & ~rst_i;
  assign wr      = acc & we_i;

  // rtc_sync[1:0] is the synchronizer; rtc_sync[2] is the edge-detect history.
  assign rtc_edge = rtc_sync[1] & ~rtc_sync[2];

  culsans_sram_1p #(
    .NUM_WORDS(NUM_WORDS)
  ) u_sram (
    .clk  (clk_i),
    .req  (acc && tgt == TGT_DRAM),
    .we   (we_i),
    .addr (aligned[IdxW+2:3]),
    .be   (be_i),
    .wdata(wdata_i),
    .rdata(sram_rdata)
  );

  always_comb begin
    reg_rdata = '0;
    unique case (tgt)
      TGT_MSIP:     reg_rdata = {63'd0, msip};
      TGT_MTIMECMP: reg_rdata = mtimecmp;
      TGT_MTIME:    reg_rdata = mtime;
      TGT_EXIT:     reg_rdata = {32'd0, exit_o};
      default:      reg_rdata = '0;
    endcase
  end

  // DRAM read data comes straight from the SRAM output register; everything
  // else (register reads, write/error responses) is captured in rdata_q.
  assign rdata_o = resp_dram ? sram_rdata : rdata_q;
  assign err_o   = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      resp_dram   <= 1'b0;
      msip        <= 1'b0;
      mtime       <= '0;
      mtimecmp    <= '1;
      exit_o      <= '0;
      rtc_sync    <= '0;
      timer_irq_o <= 1'b0;
    end else begin
      rtc_sync    <= {rtc_sync[1:0], rtc_i};
      rvalid_o    <= req_i;
      err_q       <= req_i && tgt == TGT_ERR;
      resp_dram   <= req_i && !we_i && tgt == TGT_DRAM;
      rdata_q     <= (req_i && !we_i) ? reg_rdata : '0;
      timer_irq_o <= mtime >= mtimecmp;

      if (wr && tgt == TGT_MTIME) mtime <= merge_be(mtime, wdata_i, be_i);
      else if (rtc_edge)          mtime <= mtime + 64'd1;

      if (wr && tgt == TGT_MTIMECMP) mtimecmp <= merge_be(mtimecmp, wdata_i, be_i);

      if (wr && tgt == TGT_MSIP && be_i[0]) msip <= wdata_i[0];

      if (wr && tgt == TGT_EXIT && wdata_i[0] && !exit_o[0]) exit_o <= wdata_i[31:0];
    end
  end

endmodule

// File: tb/tb_culsans_soc_top.sv
module tb_culsans_soc_top;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        rtc_i = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [63:0] addr_i = '0;
  logic [7:0]  be_i = '0;
  logic [63:0] wdata_i = '0;
  logic        gnt_o, rvalid_o, err_o, timer_irq_o, ipi_o;
  logic [63:0] rdata_o, boot_addr_o;
  logic        debug_req_i = 1'b0;
  logic        debug_req_o;
  logic [31:0] exit_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  culsans_soc_top dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .rtc_i      (rtc_i),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .be_i       (be_i),
    .wdata_i    (wdata_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .timer_irq_o(timer_irq_o),
    .ipi_o      (ipi_o),
    .debug_req_i(debug_req_i),
    .debug_req_o(debug_req_o),
    .boot_addr_o(boot_addr_o),
    .exit_o     (exit_o)
  );

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request: driven on the falling edge, response sampled 1ns after the
  // accepting rising edge.
  task automatic xfer(input logic w, input logic [63:0] a, input logic [7:0] b,
                      input logic [63:0] d, output logic v, output logic [63:0] rd,
                      output logic er);
    @(negedge clk);
    req_i = 1'b1; we_i = w; addr_i = a; be_i = b; wdata_i = d;
    @(posedge clk);
    #1;
    v = rvalid_o; rd = rdata_o; er = err_o;
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [63:0] a, input logic [63:0] exp);
    logic v, er;
    logic [63:0] rd;
    xfer(1'b0, a, 8'h00, 64'd0, v, rd, er);
    check({name, "_rvalid"}, {63'd0, v}, 64'd1);
    check({name, "_rdata"}, rd, exp);
  endtask

  task automatic wr_do(input logic [63:0] a, input logic [7:0] b, input logic [63:0] d);
    logic v, er;
    logic [63:0] rd;
    xfer(1'b1, a, b, d, v, rd, er);
  endtask

  task automatic rtc_pulse();
    rtc_i = 1'b1;
    repeat (5) @(posedge clk);
    rtc_i = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  initial begin
    logic v, er;
    logic [63:0] rd;

    vecs[0]  = '{1'b1, 64'h8010_0000, 8'hFF, 64'hDEAD_BEEF_0123_4567, 64'd0, 1'b0};
    vecs[1]  = '{1'b0, 64'h8010_0000, 8'h00, 64'd0, 64'hDEAD_BEEF_0123_4567, 1'b0};
    vecs[2]  = '{1'b1, 64'h8000_0008, 8'hFF, 64'd0, 64'd0, 1'b0};
    vecs[3]  = '{1'b1, 64'h8000_0008, 8'h0F, 64'hFFFF_FFFF_AAAA_5555, 64'd0, 1'b0};
    vecs[4]  = '{1'b0, 64'h8000_000C, 8'h00, 64'd0, 64'h0000_0000_AAAA_5555, 1'b0};
    vecs[5]  = '{1'b0, 64'h1000_0000, 8'h00, 64'd0, 64'd0, 1'b1};
    vecs[6]  = '{1'b1, 64'h1000_0000, 8'hFF, 64'h1234, 64'd0, 1'b1};
    vecs[7]  = '{1'b1, 64'h0200_4000, 8'hFF, 64'h0000_0000_0000_00FF, 64'd0, 1'b0};
    vecs[8]  = '{1'b0, 64'h0200_4000, 8'h00, 64'd0, 64'h0000_0000_0000_00FF, 1'b0};
    vecs[9]  = '{1'b1, 64'h0200_4000, 8'h01, 64'h5555_5555_5555_55AA, 64'd0, 1'b0};
    vecs[10] = '{1'b0, 64'h0200_4000, 8'h00, 64'd0, 64'h0000_0000_0000_00AA, 1'b0};
    vecs[11] = '{1'b1, 64'h0200_0000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b0};
    vecs[12] = '{1'b0, 64'h0200_0000, 8'h00, 64'd0, 64'd0, 1'b0};
    vecs[13] = '{1'b0, 64'hC000_0000, 8'h00, 64'd0, 64'd0, 1'b1};
    vecs[14] = '{1'b0, 64'h7FFF_FFF8, 8'h00, 64'd0, 64'd0, 1'b1};
    vecs[15] = '{1'b0, 64'h8000_2000, 8'h00, 64'd0, 64'hDEAD_BEEF_0123_4567, 1'b0};
    vecs[16] = '{1'b0, 64'h0000_3000, 8'h00, 64'd0, 64'd0, 1'b0};
    vecs[17] = '{1'b0, 64'h0200_0008, 8'h00, 64'd0, 64'd0, 1'b1};

    // Reset state; a request held during reset must get no response.
    debug_req_i = 1'b1;
    req_i = 1'b1; addr_i = 64'h8010_0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", {63'd0, gnt_o}, 64'd1);
    check("rst_rvalid", {63'd0, rvalid_o}, 64'd0);
    check("rst_rdata", rdata_o, 64'd0);
    check("rst_err", {63'd0, err_o}, 64'd0);
    check("rst_exit", {32'd0, exit_o}, 64'd0);
    check("rst_irq", {63'd0, timer_irq_o}, 64'd0);
    check("rst_ipi", {63'd0, ipi_o}, 64'd0);
    check("boot_addr", boot_addr_o, 64'h8010_0000);
    check("debug_req", {63'd0, debug_req_o}, 64'd0);
    req_i = 1'b0;
    #1;
    check("gnt_low", {63'd0, gnt_o}, 64'd0);
    @(negedge clk);
    rst_i = 1'b0;

    for (int i = 0; i < 18; i++) begin
      xfer(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, v, rd, er);
      check($sformatf("vec%0d_rvalid", i), {63'd0, v}, 64'd1);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {63'd0, er}, {63'd0, vecs[i].exp_err});
    end
    check("ipi_after_msip0", {63'd0, ipi_o}, 64'd0);

    // Back-to-back requests, then idle.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 64'h8000_0000;
    @(posedge clk); #1;
    check("b2b_0_rvalid", {63'd0, rvalid_o}, 64'd1);
    check("b2b_0_rdata", rdata_o, 64'hDEAD_BEEF_0123_4567);
    @(negedge clk);
    addr_i = 64'h1000_0000;
    @(posedge clk); #1;
    check("b2b_1_rvalid", {63'd0, rvalid_o}, 64'd1);
    check("b2b_1_err", {63'd0, err_o}, 64'd1);
    check("b2b_1_rdata", rdata_o, 64'd0);
    req_i = 1'b0;
    @(posedge clk); #1;
    check("b2b_idle_rvalid", {63'd0, rvalid_o}, 64'd0);

    // Exit register.
    wr_do(64'h3000, 8'hFF, 64'h2);
    check("exit_bit0_clear", {32'd0, exit_o}, 64'd0);
    wr_do(64'h3000, 8'hFF, 64'h1);
    check("exit_set", {32'd0, exit_o}, 64'd1);
    wr_do(64'h3000, 8'hFF, 64'hFF);
    check("exit_sticky", {32'd0, exit_o}, 64'd1);
    rd_check("exit_read", 64'h3000, 64'd1);

    // RTC-driven mtime and timer interrupt.
    wr_do(64'h0200_BFF8, 8'hFF, 64'd0);
    repeat (5) rtc_pulse();
    rd_check("mtime5", 64'h0200_BFF8, 64'd5);
    wr_do(64'h0200_4000, 8'hFF, 64'd3);
    repeat (2) @(posedge clk);
    #1;
    check("irq_set", {63'd0, timer_irq_o}, 64'd1);
    wr_do(64'h0200_4000, 8'hFF, 64'hFF);
    repeat (2) @(posedge clk);
    #1;
    check("irq_clr", {63'd0, timer_irq_o}, 64'd0);

    // mtime wrap.
    wr_do(64'h0200_BFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    rtc_pulse();
    rd_check("mtime_wrap", 64'h0200_BFF8, 64'd0);

    // RTC rise is counted on the third clock edge after it.
    @(negedge clk);
    rtc_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rtc_lat2", dut.mtime, 64'd0);
    @(posedge clk); #1;
    check("rtc_lat3", dut.mtime, 64'd1);
    repeat (4) @(posedge clk);
    rtc_i = 1'b0;
    repeat (4) @(posedge clk);

    // msip.
    wr_do(64'h0200_0000, 8'hFF, 64'd1);
    check("ipi_set", {63'd0, ipi_o}, 64'd1);
    rd_check("msip_read", 64'h0200_0000, 64'd1);

    // Reset asserted mid-response clears rvalid next cycle.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = 64'h8000_0000;
    @(posedge clk); #1;
    check("mid_rvalid_pre", {63'd0, rvalid_o}, 64'd1);
    rst_i = 1'b1; req_i = 1'b0;
    @(posedge clk); #1;
    check("mid_rvalid_post", {63'd0, rvalid_o}, 64'd0);
    check("post_rst_exit", {32'd0, exit_o}, 64'd0);
    check("post_rst_ipi", {63'd0, ipi_o}, 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    rd_check("post_rst_mtime", 64'h0200_BFF8, 64'd0);
    rd_check("post_rst_mtimecmp", 64'h0200_4000, 64'hFFFF_FFFF_FFFF_FFFF);
    rd_check("post_rst_dram0", 64'h8000_0000, 64'hDEAD_BEEF_0123_4567);
    rd_check("post_rst_dram1", 64'h8000_0008, 64'h0000_0000_AAAA_5555);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
